shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter for the datapath. It succeeds the single-cycle combinational 32-bit shift unit. It adds configurable data width, a configurable number of pipeline register stages, rotate operations, illegal-op flagging, and a valid/ready handshake on both sides. It sits between the register-read/operand stage and writeback, in parallel with the ALU, and serves SLL/SRL/SRA (plus ROR/ROL when enabled).

---
 rtl/shift_pkg.sv | 28 ++
 rtl/shift_stage.sv | 79 +++++++
 rtl/shift_pipe.sv | 81 ++++++++
 tb/tb_shift_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Optional feature macro: SHIFT_PIPE_ROTATE_EN (builds ROR/ROL support).
package shift_pkg;

  localparam int SHIFT_CTRL_W = 3;

  typedef enum logic [SHIFT_CTRL_W-1:0] {
    SLL = 3'b000,
    SRL = 3'b001,
    SRA = 3'b010,
    ROR = 3'b011,
    ROL = 3'b100
  } shift_op_e;

  // True for operation codes this build can execute; rotates only when compiled in.
  function automatic logic is_legal_op(input logic [SHIFT_CTRL_W-1:0] op);
    case (op)
      SLL, SRL, SRA: return 1'b1;
`ifdef SHIFT_PIPE_ROTATE_EN
      ROR, ROL:      return 1'b1;
`else
      ROR, ROL:      return 1'b0;
`endif
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the barrel shifter: mux levels FIRST_LVL..LAST_LVL
// followed by the stage register. Rotate paths exist only with SHIFT_PIPE_ROTATE_EN.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FIRST_LVL = 0,
  parameter int LAST_LVL  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pipe_en,
  input  logic                       src_valid,
  input  logic [SHIFT_CTRL_W-1:0]    src_op,
  input  logic [$clog2(WIDTH)-1:0]   src_shamt,
  input  logic                       src_fill,
  input  logic                       src_err,
  input  logic [WIDTH-1:0]           src_data,
  output logic                       dst_valid,
  output logic [SHIFT_CTRL_W-1:0]    dst_op,
  output logic [$clog2(WIDTH)-1:0]   dst_shamt,
  output logic                       dst_fill,
  output logic                       dst_err,
  output logic [WIDTH-1:0]           dst_data
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0] amt_bits;
  int                 amt;

  // Mux levels owned by this stage: level k shifts by 2^k when shamt bit k is set.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    shifted  = src_data;
    amt_bits = '0;
    amt      = 0;
    for (int k = FIRST_LVL; k <= LAST_LVL; k++) begin
      amt_bits = src_shamt >> k;
      amt      = 1 << k;
      if (amt_bits[0]) begin
        case (src_op)
          SLL: shifted = shifted << amt;
          SRL: shifted = shifted >> amt;
          SRA: shifted = (shifted >> amt) | (src_fill ? ~({WIDTH{1'b1}} >> amt) : '0);
`ifdef SHIFT_PIPE_ROTATE_EN
          ROR: shifted = (shifted >> amt) | (shifted << (WIDTH - amt));
          ROL: shifted = (shifted << amt) | (shifted >> (WIDTH - amt));
`endif
          // Illegal (or compiled-out rotate) codes pass the operand through untouched.
          default: shifted = shifted;
        endcase
      end
    end
  end

  // Stage register: advance on pipe_en, hold otherwise, clear on reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    if (reset) begin
      // NOTE: the data fields are cleared too, because shift_out and out_err must read 0 after reset.
      dst_valid <= 1'b0;
      dst_op    <= '0;
      dst_shamt <= '0;
      dst_fill  <= 1'b0;
      dst_err   <= 1'b0;
      dst_data  <= '0;
    end else if (pipe_en) begin
      dst_valid <= src_valid;
      dst_op    <= src_op;
      dst_shamt <= src_shamt;
      dst_fill  <= src_fill;
      dst_err   <= src_err;
      dst_data  <= shifted;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined, parametrised barrel shifter with valid/ready on both sides.
// Optional feature macro: SHIFT_PIPE_ROTATE_EN (ROR/ROL legal when defined).
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SHIFT_CTRL_W-1:0]  shift_ctrl,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [WIDTH-1:0]         shift_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         shift_out,
  output logic                     out_err
);

  localparam int LEVELS = $clog2(WIDTH);

  // Index 0 is the accepted request; index s+1 is the register of stage s.
  logic                    stage_valid [0:PIPE_STAGES];
  logic [SHIFT_CTRL_W-1:0] stage_op    [0:PIPE_STAGES];
  logic [LEVELS-1:0]       stage_shamt [0:PIPE_STAGES];
  logic                    stage_fill  [0:PIPE_STAGES];
  logic                    stage_err   [0:PIPE_STAGES];
  logic [WIDTH-1:0]        stage_data  [0:PIPE_STAGES];

  logic pipe_en;

  // The whole pipe moves together whenever the output slot is empty or being drained.
  assign pipe_en  = !out_valid || out_ready;
  assign in_ready = pipe_en;

  // Request entry: the SRA fill bit and legality are decided once, at accept.
  assign stage_valid[0] = in_valid;
  assign stage_op[0]    = shift_ctrl;
  assign stage_shamt[0] = shamt;
  assign stage_fill[0]  = shift_in[WIDTH-1];
  assign stage_err[0]   = !is_legal_op(shift_ctrl);
  assign stage_data[0]  = shift_in;

  // Level k lives in stage floor(k*PIPE_STAGES/LEVELS); the bounds below are that inverse.
  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    localparam int FIRST = (s * LEVELS + PIPE_STAGES - 1) / PIPE_STAGES;
    localparam int LAST  = ((s + 1) * LEVELS + PIPE_STAGES - 1) / PIPE_STAGES - 1;

    shift_stage #(
      .WIDTH     (WIDTH),
      .FIRST_LVL (FIRST),
      .LAST_LVL  (LAST)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .pipe_en   (pipe_en),
      .src_valid (stage_valid[s]),
      .src_op    (stage_op[s]),
      .src_shamt (stage_shamt[s]),
      .src_fill  (stage_fill[s]),
      .src_err   (stage_err[s]),
      .src_data  (stage_data[s]),
      .dst_valid (stage_valid[s+1]),
      .dst_op    (stage_op[s+1]),
      .dst_shamt (stage_shamt[s+1]),
      .dst_fill  (stage_fill[s+1]),
      .dst_err   (stage_err[s+1]),
      .dst_data  (stage_data[s+1])
    );
  end

  assign out_valid = stage_valid[PIPE_STAGES];
  assign shift_out = stage_data[PIPE_STAGES];
  assign out_err   = stage_err[PIPE_STAGES];

  // Control fields of the last stage have no consumer once all levels are applied.
  wire unused_tail = ^{stage_op[PIPE_STAGES], stage_shamt[PIPE_STAGES], stage_fill[PIPE_STAGES]};

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=32, PIPE_STAGES=2): directed cases
// from the feature list plus randomized traffic against a queue-based model.
module tb_shift_pipe;

  localparam int WIDTH       = 32;
  localparam int PIPE_STAGES = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        shift_ctrl;
  logic [4:0]        shamt;
  logic [WIDTH-1:0]  shift_in;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  shift_out;
  logic              out_err;

  shift_pipe #(
    .WIDTH       (WIDTH),
    .PIPE_STAGES (PIPE_STAGES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .shift_ctrl (shift_ctrl),
    .shamt      (shamt),
    .shift_in   (shift_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .shift_out  (shift_out),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
    int               acc_cyc;
    int               acc_stalls;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   stalls = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference result from the operation definitions, using a doubled word for rotates.
  function automatic logic [WIDTH:0] model(input logic [2:0] op, input int s, input logic [WIDTH-1:0] x);
    logic [2*WIDTH-1:0] xx;
    logic [WIDTH-1:0]   r;
    logic               rot_en;
    xx = {x, x};
`ifdef SHIFT_PIPE_ROTATE_EN
    rot_en = 1'b1;
`else
    rot_en = 1'b0;
`endif
    case (op)
      3'd0: return {1'b0, x << s};
      3'd1: return {1'b0, x >> s};
      3'd2: return {1'b0, WIDTH'($signed(x) >>> s)};
      3'd3: begin
        xx = xx >> s;
        r  = xx[WIDTH-1:0];
        return rot_en ? {1'b0, r} : {1'b1, x};
      end
      3'd4: begin
        xx = xx << s;
        r  = xx[2*WIDTH-1:WIDTH];
        return rot_en ? {1'b0, r} : {1'b1, x};
      end
      default: return {1'b1, x};
    endcase
  endfunction

  // One clock of traffic: drive on the falling edge, check the model's view of the
  // output slot, then record what the next rising edge will accept and drain.
  task automatic step(input logic v, input logic [2:0] op, input logic [4:0] sh,
                      input logic [WIDTH-1:0] x, input logic ordy,
                      input logic use_exp, input logic [WIDTH-1:0] ed, input logic ee,
                      output logic accepted);
    logic         exp_valid;
    logic [WIDTH:0] m;
    exp_t         e;
    @(negedge clk);
    in_valid   = v;
    shift_ctrl = op;
    shamt      = sh;
    shift_in   = x;
    out_ready  = ordy;
    #1;
    exp_valid = (sb.size() > 0) &&
                (cyc >= sb[0].acc_cyc + PIPE_STAGES + stalls - sb[0].acc_stalls);
    check("out_valid", out_valid, exp_valid);
    check("in_ready", in_ready, !exp_valid || ordy);
    if (sb.size() == 0) check("no_stale", out_valid, 1'b0);
    if (exp_valid) begin
      check("shift_out", shift_out, sb[0].data);
      check("out_err", out_err, sb[0].err);
      if (ordy) void'(sb.pop_front());
      else      stalls++;
    end
    accepted = v && (!exp_valid || ordy);
    if (accepted) begin
      m = model(op, int'(sh), x);
      e.data       = use_exp ? ed : m[WIDTH-1:0];
      e.err        = use_exp ? ee : m[WIDTH];
      e.acc_cyc    = cyc;
      e.acc_stalls = stalls;
      sb.push_back(e);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 5'd0, '0, 1'b1, 1'b0, '0, 1'b0, acc);
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] sh, input logic [WIDTH-1:0] x,
                      input logic [WIDTH-1:0] ed, input logic ee);
    logic acc;
    step(1'b1, op, sh, x, 1'b1, 1'b1, ed, ee, acc);
    if (!acc) check("send_accept", acc, 1'b1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset      = 1'b1;
    in_valid   = 1'b1;
    shift_ctrl = 3'd0;
    shamt      = 5'd1;
    shift_in   = $urandom;
    out_ready  = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_shift_out", shift_out, '0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    cyc += 2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [31:0] ror_exp, rol_exp;
    logic        rot_err;
    int          idx;

    reset = 1'b1; in_valid = 1'b0; shift_ctrl = '0; shamt = '0; shift_in = '0; out_ready = 1'b1;
    pulse_reset();

    // SLL 10 by 1/2/3 back-to-back.
    send(3'd0, 5'd1, 32'd10, 32'd20, 1'b0);
    send(3'd0, 5'd2, 32'd10, 32'd40, 1'b0);
    send(3'd0, 5'd3, 32'd10, 32'd80, 1'b0);
    idle(4);

    // Logical vs arithmetic right shifts of a negative operand.
    send(3'd1, 5'd1,  32'hFFFFFFEF, 32'h7FFFFFF7, 1'b0);
    send(3'd1, 5'd10, 32'hFFFFFFEF, 32'h003FFFFF, 1'b0);
    send(3'd1, 5'd31, 32'hFFFFFFEF, 32'h00000001, 1'b0);
    send(3'd2, 5'd1,  32'hFFFFFFEF, 32'hFFFFFFF7, 1'b0);
    send(3'd2, 5'd10, 32'hFFFFFFEF, 32'hFFFFFFFF, 1'b0);
    send(3'd2, 5'd31, 32'hFFFFFFEF, 32'hFFFFFFFF, 1'b0);
    send(3'd0, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);

    // Rotates: result depends on whether rotate support is compiled in.
`ifdef SHIFT_PIPE_ROTATE_EN
    ror_exp = 32'hC0000000; rol_exp = 32'h00000018; rot_err = 1'b0;
`else
    ror_exp = 32'h80000001; rol_exp = 32'h80000001; rot_err = 1'b1;
`endif
    send(3'd3, 5'd1, 32'h80000001, ror_exp, rot_err);
    send(3'd4, 5'd4, 32'h80000001, rol_exp, rot_err);

    // Illegal op passes through flagged; the following legal op is clean.
    send(3'd7, 5'd4, 32'h12345678, 32'h12345678, 1'b1);
    send(3'd0, 5'd4, 32'h12345678, 32'h23456780, 1'b0);
    idle(4);

    // Backpressure: 5 requests offered back-to-back, consumer stalls in cycles 3-5.
    idx = 0;
    for (int i = 0; i < 20; i++) begin
      step(idx < 5, 3'd0, 5'(idx), 32'h0000_0101, !(i >= 3 && i <= 5),
           1'b1, 32'h0000_0101 << idx, 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_all_sent", idx, 5);

    // Reset with two requests in flight: nothing may emerge afterwards.
    send(3'd0, 5'd1, 32'h1111_1111, 32'h2222_2222, 1'b0);
    send(3'd0, 5'd2, 32'h1111_1111, 32'h4444_4444, 1'b0);
    pulse_reset();
    idle(5);

    // Randomized traffic with random valid and random backpressure.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 5'($urandom),
           $urandom, ($urandom_range(0, 3) != 0), 1'b0, '0, 1'b0, acc);
    end

    // Drain whatever is still in flight, bounded.
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    check("drain_empty", sb.size(), 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
